// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op codes, FSM states and datapath width for the mul/div unit
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - 2*WIDTH accumulator with shift-add / restoring step and sign fixup
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // m is the addend: |a| for multiply, |b| (divisor) for divide
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_q, div_d;
  logic               div0_q, div0_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_try;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  // operand capture on load, one multiply or divide iteration per step
  always_comb begin
    acc_d   = acc_q;
    m_d     = m_q;
    a_raw_d = a_raw_q;
    div_d   = div_q;
    div0_d  = div0_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;

    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    rem_try = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge  = (rem_try >= {1'b0, m_q});
    rem_new = rem_ge ? WIDTH'(rem_try - {1'b0, m_q}) : rem_try[WIDTH-1:0];

    if (load) begin
      m_d     = is_div ? mag_b : mag_a;
      acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      a_raw_d = a;
      div_d   = is_div;
      div0_d  = (b == '0);
      neg_q_d = a_neg ^ b_neg;
      neg_r_d = a_neg;
    end else if (step) begin
      if (div_q) begin
        acc_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  // result sign correction; divide by zero returns all-ones quotient and the raw dividend
  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (div0_q) begin
        res_lo = '1;
        res_hi = a_raw_q;
      end else begin
        res_lo = neg_q_q ? -quo : quo;
        res_hi = neg_r_q ? -rem : rem;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      m_q     <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      m_q     <= m_d;
      a_raw_q <= a_raw_d;
      div_q   <= div_d;
      div0_q  <= div0_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/DIV unit owning the architectural HI/LO registers
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             dp_load, dp_step;
  logic             op_is_div, op_is_signed;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_is_signed = (op == OP_MULT) || (op == OP_DIV);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (op_is_div),
    .is_signed (op_is_signed),
    .a         (a),
    .b         (b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // next-state, iteration counter and HI/LO update; flush beats start and aborts without writing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              dp_load = 1'b1;
              cnt_d   = CW'(WIDTH-1);
              state_d = S_CALC;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          dp_step = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // {hi, lo} from plain 64-bit / signed integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int sx, sy, q, m;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      3'b000: r = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      3'b001: r = {32'h0, x} * {32'h0, y};
      3'b010: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m, q};
        end
      end
      3'b011: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: r = '0;
    endcase
    return r;
  endfunction

  // issue one op at a negedge and wait for done; optionally poke an ignored DIVU start at cycle poke
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    repeat (100) begin
      lat++;
      if (busy) bcnt++;
      if (done) break;
      start = (lat == poke);
      if (lat == poke) op = 3'b011;
      @(negedge clk);
    end
    start = 1'b0;
    rh = hi; rl = lo;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0)  begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    @(negedge clk);
  endtask

  task automatic test_multu_max;
    logic [31:0] rh, rl; int lat, bcnt;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, rh, rl, lat, bcnt);
    total++; if (lat !== 34)          begin bad++; $display("FAIL multu_latency got=%0d want=34", lat); end
    total++; if (bcnt !== 33)         begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", bcnt); end
    total++; if (rh !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", rh); end
    total++; if (rl !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", rl); end
    exp_hi = 32'hFFFFFFFE; exp_lo = 32'h1;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single_cycle got=%b want=0", done); end
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [6] = '{3'b000, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010};
    logic [31:0] t_a  [6] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'd7};
    logic [31:0] t_b  [6] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFE};
    logic [31:0] t_hi [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h0, 32'hF, 32'h1};
    logic [31:0] t_lo [6] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0FFFFFFF, 32'hFFFFFFFD};
    logic [31:0] rh, rl; int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 0, rh, rl, lat, bcnt);
      total++; if (rh !== t_hi[i]) begin bad++; $display("FAIL directed%0d_hi got=%h want=%h", i, rh, t_hi[i]); end
      total++; if (rl !== t_lo[i]) begin bad++; $display("FAIL directed%0d_lo got=%h want=%h", i, rl, t_lo[i]); end
      total++; if (lat !== 34)     begin bad++; $display("FAIL directed%0d_latency got=%0d want=34", i, lat); end
      exp_hi = t_hi[i]; exp_lo = t_lo[i];
    end
  endtask

  task automatic test_move;
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi got=%h want=12345678", hi); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_flags got=%b%b want=00", busy, done); end
    op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clk);
    total++; if (lo !== 32'h9ABCDEF0) begin bad++; $display("FAIL mtlo_lo got=%h want=9abcdef0", lo); end
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mtlo_hi_kept got=%h want=12345678", hi); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mtlo_flags got=%b%b want=00", busy, done); end
    op = 3'b110; a = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0)
      begin bad++; $display("FAIL reserved_op got=%h/%h/%b want=12345678/9abcdef0/0", hi, lo, busy); end
    op = 3'b100; flush = 1'b1; a = 32'h55;
    @(negedge clk);
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL flush_mthi got=%h want=12345678", hi); end
    start = 1'b0; flush = 1'b0;
    exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_flush;
    logic [31:0] rh, rl; int lat, bcnt, seen;
    start = 1'b1; op = 3'b000; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b want=0", done); end
    total++; if (hi !== exp_hi || lo !== exp_lo)
      begin bad++; $display("FAIL flush_hilo got=%h/%h want=%h/%h", hi, lo, exp_hi, exp_lo); end
    seen = 0;
    repeat (40) begin if (done || busy) seen++; @(negedge clk); end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_activity got=%0d want=0", seen); end
    run_op(3'b001, 32'd6, 32'd7, 0, rh, rl, lat, bcnt);
    total++; if (rh !== 32'h0 || rl !== 32'd42)
      begin bad++; $display("FAIL reissue_multu got=%h/%h want=0/2a", rh, rl); end
    total++; if (lat !== 34) begin bad++; $display("FAIL reissue_latency got=%0d want=34", lat); end
    exp_hi = 32'h0; exp_lo = 32'd42;
  endtask

  task automatic test_flush_fix;
    start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fix_busy got=%b want=1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL fix_flush_flags got=%b%b want=00", busy, done); end
    total++; if (hi !== exp_hi || lo !== exp_lo)
      begin bad++; $display("FAIL fix_flush_hilo got=%h/%h want=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rh, rl, x, y; logic [63:0] e; int lat, bcnt;
    x = $urandom; y = $urandom;
    e = model(3'b000, x, y);
    run_op(3'b000, x, y, 5, rh, rl, lat, bcnt);
    total++; if ({rh, rl} !== e) begin bad++; $display("FAIL b2b_first got=%h%h want=%h", rh, rl, e); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_first_latency got=%0d want=34", lat); end
    x = $urandom; y = $urandom_range(1, 1000);
    e = model(3'b010, x, y);
    run_op(3'b010, x, y, 0, rh, rl, lat, bcnt);
    total++; if ({rh, rl} !== e) begin bad++; $display("FAIL b2b_second got=%h%h want=%h", rh, rl, e); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_second_latency got=%0d want=34", lat); end
    exp_hi = e[63:32]; exp_lo = e[31:0];
  endtask

  task automatic test_random;
    logic [31:0] rh, rl, x, y; logic [2:0] o; logic [63:0] e; int lat, bcnt;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      if (i % 5 == 0) y = 32'h0;
      if (i % 7 == 1) y = $urandom_range(1, 16);
      if (i % 6 == 2) y = -$urandom_range(1, 16);
      e = model(o, x, y);
      run_op(o, x, y, 0, rh, rl, lat, bcnt);
      total++; if ({rh, rl} !== e)
        begin bad++; $display("FAIL random%0d op=%0d a=%h b=%h got=%h%h want=%h", i, o, x, y, rh, rl, e); end
      total++; if (lat !== 34) begin bad++; $display("FAIL random%0d_latency got=%0d want=34", i, lat); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    start = 1'b1; op = 3'b010; a = $urandom; b = $urandom_range(1, 100);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL midreset_flags got=%b%b want=00", busy, done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0)
      begin bad++; $display("FAIL midreset_hilo got=%h/%h want=0/0", hi, lo); end
    reset = 1'b0;
    seen = 0;
    repeat (40) begin if (done) seen++; @(negedge clk); end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", seen); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    test_reset;
    test_multu_max;
    test_directed;
    test_move;
    test_flush;
    test_flush_fix;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
